// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder side of the CPU memory-stage data interface. It is a word-addressed
// WIDTH-bit data memory with a fixed number of wait states and a valid/ready
// handshake. While an access is in flight it stalls the CPU pipeline.
//
// Access timing: a request accepted in cycle N produces a one-cycle RespValid
// pulse in cycle N+1+WAIT_CYCLES. The responder then spends one IDLE cycle
// before it can accept the next request.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   ReqValid   in   CPU presents a request
//   ReqWrite   in   1 = write, 0 = read (sampled on acceptance)
//   ReqAddr    in   word address
//   ReqWData   in   write data
//   ReqReady   out  responder can accept a request this cycle
//   RespValid  out  one-cycle completion pulse
//   RespData   out  read data, or the echoed write data (0 when out of range)
//   RespErr    out  address out of range; meaningful with RespValid
//   Stall      out  hold the CPU pipeline
//   ReadCount  out  (DMEM_STATS_EN only) saturating count of in-range reads
//   WriteCount out  (DMEM_STATS_EN only) saturating count of in-range writes
//
// Optional feature: define DMEM_STATS_EN to add the ReadCount/WriteCount
// statistics outputs.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int WIDTH       = 48,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ReqValid,
    input  logic             ReqWrite,
    input  logic [WIDTH-1:0] ReqAddr,
    input  logic [WIDTH-1:0] ReqWData,
    output logic             ReqReady,
    output logic             RespValid,
    output logic [WIDTH-1:0] RespData,
    output logic             RespErr,
    output logic             Stall
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]      ReadCount,
    output logic [15:0]      WriteCount
`endif
);

    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);
    localparam logic             WAIT_ZERO = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       cnt_r;
    logic             write_r;
    logic [WIDTH-1:0] addr_r;
    logic [WIDTH-1:0] wdata_r;

    logic             accept_s;
    logic             go_resp_s;
    logic             acc_write_s;
    logic [WIDTH-1:0] acc_addr_s;
    logic [WIDTH-1:0] acc_wdata_s;
    logic             acc_in_range_s;
    logic [AW-1:0]    acc_idx_s;
    logic             mem_we_s;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Acceptance, the edge that enters RESP, and which request that edge services.
    always_comb begin
        accept_s    = 1'b0;
        go_resp_s   = 1'b0;
        acc_write_s = write_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            accept_s    = ReqValid;
            // With no wait states RESP follows acceptance directly, so the
            // access has to use the live request rather than the latched copy.
            go_resp_s   = ReqValid & WAIT_ZERO;
            acc_write_s = ReqWrite;
            acc_addr_s  = ReqAddr;
            acc_wdata_s = ReqWData;
        end else if (state_r == ST_BUSY) begin
            go_resp_s = (cnt_r == 4'd1);
        end else begin
            go_resp_s = 1'b0;
        end
        acc_in_range_s = (acc_addr_s < DEPTH_W);
        acc_idx_s      = acc_addr_s[AW-1:0];
        // Gating with Reset keeps a request presented during reset from
        // landing in the array.
        mem_we_s       = go_resp_s & acc_write_s & acc_in_range_s & Reset;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = WAIT_ZERO ? ST_RESP : ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (go_resp_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; Stall drops in RESP so the CPU advances as it consumes RespData.
    always_comb begin
        ReqReady  = 1'b0;
        RespValid = 1'b0;
        Stall     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ReqReady = 1'b1;
                Stall    = ReqValid;
            end
            ST_BUSY: Stall     = 1'b1;
            ST_RESP: RespValid = 1'b1;
            default: begin
                ReqReady  = 1'b0;
                RespValid = 1'b0;
                Stall     = 1'b0;
            end
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            addr_r  <= {WIDTH{1'b0}};
            wdata_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= WAIT_LOAD;
            write_r <= ReqWrite;
            addr_r  <= ReqAddr;
            wdata_r <= ReqWData;
        end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response data/error registers; they hold between responses.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            RespData <= {WIDTH{1'b0}};
            RespErr  <= 1'b0;
        end else if (go_resp_s) begin
            if (!acc_in_range_s) begin
                RespData <= {WIDTH{1'b0}};
                RespErr  <= 1'b1;
            end else if (acc_write_s) begin
                RespData <= acc_wdata_s;
                RespErr  <= 1'b0;
            end else begin
                RespData <= mem_r[acc_idx_s];
                RespErr  <= 1'b0;
            end
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[acc_idx_s] <= acc_wdata_s;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] read_cnt_r;
    logic [15:0] write_cnt_r;

    // Saturating counters of completed in-range reads and writes.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            read_cnt_r  <= 16'd0;
            write_cnt_r <= 16'd0;
        end else if (go_resp_s && acc_in_range_s) begin
            if (acc_write_s) begin
                if (write_cnt_r != 16'hFFFF) begin
                    write_cnt_r <= write_cnt_r + 16'd1;
                end
            end else begin
                if (read_cnt_r != 16'hFFFF) begin
                    read_cnt_r <= read_cnt_r + 16'd1;
                end
            end
        end
    end

    assign ReadCount  = read_cnt_r;
    assign WriteCount = write_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench. The driver pushes the expected response of every accepted
// request into a queue, computed from a plain array model of the memory. An
// independent monitor pops and compares whenever RespValid is seen. A second
// instance with zero wait states checks back-to-back handshaking.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WAIT_A = 2;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_write, a_rdy, a_rv, a_err, a_stall;
    logic [47:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_write, b_rdy, b_rv, b_err, b_stall;
    logic [47:0] b_addr, b_wdata, b_rdata;
`ifdef DMEM_STATS_EN
    logic [15:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

    typedef struct {
        logic [47:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [47:0] model_mem [256];
    int          model_rd;
    int          model_wr;
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          stall_run;

    dmem_responder #(.WIDTH(48), .DEPTH(256), .WAIT_CYCLES(WAIT_A)) dut_a (
        .CLK(clk), .Reset(rst_n), .ReqValid(a_valid), .ReqWrite(a_write),
        .ReqAddr(a_addr), .ReqWData(a_wdata), .ReqReady(a_rdy),
        .RespValid(a_rv), .RespData(a_rdata), .RespErr(a_err), .Stall(a_stall)
`ifdef DMEM_STATS_EN
        , .ReadCount(a_rd_cnt), .WriteCount(a_wr_cnt)
`endif
    );

    dmem_responder #(.WIDTH(48), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .CLK(clk), .Reset(rst_n), .ReqValid(b_valid), .ReqWrite(b_write),
        .ReqAddr(b_addr), .ReqWData(b_wdata), .ReqReady(b_rdy),
        .RespValid(b_rv), .RespData(b_rdata), .RespErr(b_err), .Stall(b_stall)
`ifdef DMEM_STATS_EN
        , .ReadCount(b_rd_cnt), .WriteCount(b_wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check response latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    // Monitor: pops the scoreboard whenever instance A completes an access.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run = 0;
        end else begin
            if (a_stall) stall_run++;
            if (a_rv) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: RespValid with no request outstanding");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_data", 64'(a_rdata), 64'(e.data));
                    check("resp_err", 64'(a_err), 64'(e.err));
                    check("resp_latency", 64'(cyc), 64'(e.due));
                    check("stall_in_resp", 64'(a_stall), 64'd0);
                    check("stall_cycles", 64'(stall_run), 64'(WAIT_A + 1));
                end
                stall_run = 0;
            end
        end
    end

    // Issue one request to instance A; record its expected response if it is
    // meant to complete.
    task automatic do_req(input logic w, input logic [47:0] addr, input logic [47:0] data,
                          input bit expect_resp);
        int   n;
        exp_t e;
        bit   inr;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_rdy && n < 50);
        if (!a_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: ReqReady low for %0d cycles", n);
            return;
        end
        a_valid = 1'b1;
        a_write = w;
        a_addr  = addr;
        a_wdata = data;
        @(posedge clk); #1;
        // Scramble the request inputs while the access is in flight.
        a_valid = 1'b0;
        a_write = 1'($urandom);
        a_addr  = rand48();
        a_wdata = rand48();
        if (expect_resp) begin
            inr    = (addr < 48'd256);
            e.err  = !inr;
            e.data = !inr ? 48'd0 : (w ? data : model_mem[addr[7:0]]);
            e.due  = cyc + WAIT_A;
            if (inr && w)  model_mem[addr[7:0]] = data;
            if (inr && w)  model_wr++;
            if (inr && !w) model_rd++;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses still outstanding", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [47:0] ra;
        logic [47:0] b_sent;
        int          r;
        n_checks = 0; n_fail = 0; cyc = 0; stall_run = 0;
        model_rd = 0; model_wr = 0;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 48'd0; a_wdata = 48'd0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 48'd0; b_wdata = 48'd0;
        b_sent  = 48'd0;

        // Reset values, during and after reset.
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 64'(a_rdy), 64'd1);
            check("rst_stall", 64'(a_stall), 64'd0);
            check("rst_rvalid", 64'(a_rv), 64'd0);
            check("rst_rdata", 64'(a_rdata), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 64'(a_rdy), 64'd1);
            check("idle_stall", 64'(a_stall), 64'd0);
            check("idle_rvalid", 64'(a_rv), 64'd0);
            check("idle_rdata", 64'(a_rdata), 64'd0);
        end

        // Preload the whole array with zeros.
        for (int i = 0; i < 256; i++) do_req(1'b1, 48'(i), 48'd0, 1'b1);

        // Directed: write then read back, untouched neighbour.
        do_req(1'b1, 48'd5, 48'h0000_DEAD_BEEF, 1'b1);
        do_req(1'b0, 48'd5, 48'd0, 1'b1);
        do_req(1'b0, 48'd6, 48'd0, 1'b1);

        // Out of range: read, aliasing write attempt, then address 0 unchanged.
        do_req(1'b0, 48'h100, 48'd0, 1'b1);
        do_req(1'b1, 48'h100, 48'h1, 1'b1);
        do_req(1'b0, 48'd0, 48'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ra = 48'(256 + $urandom_range(0, 300));
            else if (r == 1) ra = rand48() | 48'h1000;
            else if (r < 5)  ra = 48'($urandom_range(0, 7));
            else             ra = 48'($urandom_range(0, 255));
            do_req(1'($urandom), ra, rand48(), 1'b1);
        end
        drain();

        // Zero-wait instance: ReqValid held high gives accept/respond alternation.
        @(posedge clk); #1;
        b_valid = 1'b1;
        b_write = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b_addr  = 48'($urandom_range(0, 255));
            b_wdata = rand48();
            if ((k % 2) == 0) b_sent = b_wdata;
            @(negedge clk);
            if ((k % 2) == 0) begin
                check("w0_accept_rvalid", 64'(b_rv), 64'd0);
                check("w0_accept_stall", 64'(b_stall), 64'd1);
                check("w0_accept_ready", 64'(b_rdy), 64'd1);
            end else begin
                check("w0_resp_rvalid", 64'(b_rv), 64'd1);
                check("w0_resp_stall", 64'(b_stall), 64'd0);
                check("w0_resp_data", 64'(b_rdata), 64'(b_sent));
                check("w0_resp_err", 64'(b_err), 64'd0);
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;

        // Reset during BUSY abandons a pending write.
        do_req(1'b1, 48'd7, 48'hABC, 1'b0);
        rst_n = 1'b0;
        model_rd = 0;
        model_wr = 0;
        repeat (2) begin
            @(negedge clk);
            check("abort_rvalid", 64'(a_rv), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_post_rvalid", 64'(a_rv), 64'd0);
        end
`ifdef DMEM_STATS_EN
        check("abort_write_count", 64'(a_wr_cnt), 64'd0);
        check("abort_read_count", 64'(a_rd_cnt), 64'd0);
`endif
        do_req(1'b0, 48'd7, 48'd0, 1'b1);
        do_req(1'b1, 48'd9, 48'h1234, 1'b1);
        do_req(1'b0, 48'h200, 48'd0, 1'b1);
        drain();
`ifdef DMEM_STATS_EN
        check("final_read_count", 64'(a_rd_cnt), 64'(model_rd));
        check("final_write_count", 64'(a_wr_cnt), 64'(model_wr));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
